display_scan_ctrl: RTL and testbench

- Time-multiplexes the 4-bit display path between two sources: digit 0 shows the dip-switch nibble, digit 1 shows the syndrome nibble.
- Generates the source-select signal, drives the registered nibble toward the 7-segment decoder, and drives the active-low digit anodes.
- Inserts a blanking gap at every digit switch so the nibble and anode never change together. This prevents ghosting.
- Replaces the free-running 1 kHz select clock with a single-clock-domain controller.

---
 rtl/display_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: two-digit scan controller for the 4-bit display path.
// Digit 0 shows the dip-switch nibble and digit 1 shows the syndrome nibble.
// Every digit slot begins with an anode-off blanking gap, so the nibble and
// the anodes never change together. The state, counter and outputs are all
// registered. The output registers are loaded from the next-state values,
// so each output always matches the state that the controller is in.
module display_scan_ctrl #(
    parameter int CLK_HZ       = 27000000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] i,
    input  logic [3:0] p,
    output logic       sel,
    output logic [3:0] w,
    output logic [1:0] an_n,
    output logic       frame_tick
);

    localparam int DWELL = CLK_HZ / (2 * SCAN_HZ);
    localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;

    // Last count of the blanking gap and of the visible part of a slot.
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(DWELL - BLANK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    if (BLANK_CYCLES >= DWELL || DWELL < 2) begin : g_bad_params
        $error("display_scan_ctrl: BLANK_CYCLES must be < DWELL and DWELL must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Start of a slot: go to the blanking gap, or straight to SHOW when there is no gap.
    localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          sel_r, sel_s;
    logic [3:0]    w_r, w_s;
    logic [1:0]    an_n_r, an_n_s;
    logic          tick_r, tick_s;

    // Next state, slot counter and digit select. A low en overrides everything else.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        sel_s   = sel_r;
        if (!en) begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
            sel_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = SLOT_START;
                    cnt_s   = CNT_ZERO;
                    sel_s   = 1'b0;
                end
                ST_BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_s = ST_SHOW;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_SHOW: begin
                    if (cnt_r == SHOW_LAST) begin
                        state_s = SLOT_START;
                        cnt_s   = CNT_ZERO;
                        sel_s   = ~sel_r;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                    sel_s   = 1'b0;
                end
            endcase
        end
    end

    // Output values for the upcoming cycle, derived from the next state.
    // frame_tick is set for the last visible cycle of digit 1.
    always_comb begin
        an_n_s = 2'b11;
        w_s    = w_r;
        tick_s = 1'b0;
        case (state_s)
            ST_BLANK: begin
                w_s = sel_s ? p : i;
            end
            ST_SHOW: begin
                w_s    = sel_s ? p : i;
                an_n_s = sel_s ? 2'b01 : 2'b10;
                tick_s = sel_s && (cnt_s == SHOW_LAST);
            end
            default: begin
                w_s = w_r;
            end
        endcase
    end

    // State, counter and output registers with a synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            sel_r   <= 1'b0;
            w_r     <= 4'h0;
            an_n_r  <= 2'b11;
            tick_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            sel_r   <= sel_s;
            w_r     <= w_s;
            an_n_r  <= an_n_s;
            tick_r  <= tick_s;
        end
    end

    assign sel        = sel_r;
    assign w          = w_r;
    assign an_n       = an_n_r;
    assign frame_tick = tick_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl. Two instances share the stimulus: one with a
// 2-cycle blanking gap and one with no gap. A reference model tracks the
// position of the scan within a frame. It pushes the expected outputs for each
// cycle into a queue, and a monitor pops that queue and compares on every
// falling edge.
module tb_display_scan_ctrl;

    localparam int DWELL = 10;
    localparam int FRAME = 2 * DWELL;

    typedef struct packed {
        logic       sel;
        logic [3:0] w;
        logic [1:0] an;
        logic       tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] i;
    logic [3:0] p;

    logic       sel_a, sel_b;
    logic [3:0] w_a, w_b;
    logic [1:0] an_a, an_b;
    logic       tick_a, tick_b;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // Model state, one entry per instance.
    int         m_blank[2] = '{2, 0};
    bit         m_act[2];
    int         m_t[2];
    logic [3:0] m_w[2];

    display_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(50), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .en(en), .i(i), .p(p),
        .sel(sel_a), .w(w_a), .an_n(an_a), .frame_tick(tick_a)
    );

    display_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(50), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .i(i), .p(p),
        .sel(sel_b), .w(w_b), .an_n(an_b), .frame_tick(tick_b)
    );

    always #5 clk = ~clk;

    // Reference model: the expected outputs after each rising edge.
    initial begin
        exp_t e;
        int   dig;
        int   offs;
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    m_act[k] = 1'b0;
                    m_t[k]   = 0;
                    m_w[k]   = 4'h0;
                    e.sel = 1'b0; e.w = 4'h0; e.an = 2'b11; e.tick = 1'b0;
                end else if (!en) begin
                    m_act[k] = 1'b0;
                    m_t[k]   = 0;
                    e.sel = 1'b0; e.w = m_w[k]; e.an = 2'b11; e.tick = 1'b0;
                end else begin
                    if (m_act[k]) m_t[k] = (m_t[k] + 1) % FRAME;
                    else begin
                        m_act[k] = 1'b1;
                        m_t[k]   = 0;
                    end
                    dig    = m_t[k] / DWELL;
                    offs   = m_t[k] % DWELL;
                    m_w[k] = (dig == 1) ? p : i;
                    e.sel  = (dig == 1);
                    e.w    = m_w[k];
                    e.an   = (offs < m_blank[k]) ? 2'b11 : ((dig == 1) ? 2'b01 : 2'b10);
                    e.tick = (dig == 1) && (offs == DWELL - 1);
                end
                if (k == 0) q_a.push_back(e);
                else        q_b.push_back(e);
            end
        end
    end

    task automatic check_out(input string name, input exp_t act, input exp_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s outputs @%0t: got sel=%0b w=%h an_n=%b tick=%0b, want sel=%0b w=%h an_n=%b tick=%0b",
                     name, $time, act.sel, act.w, act.an, act.tick, exp.sel, exp.w, exp.an, exp.tick);
        end
        n_checks++;
        if (act.an == 2'b00) begin
            n_fail++;
            $display("FAIL %s both_anodes @%0t: got an_n=%b, want not 00", name, $time, act.an);
        end
        if (act.an != 2'b11) begin
            n_checks++;
            if (act.an != (act.sel ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL %s anode_vs_sel @%0t: got an_n=%b with sel=%0b", name, $time, act.an, act.sel);
            end
        end
    endtask

    // Monitor: compare each instance against the next queued expectation.
    initial begin
        exp_t act;
        exp_t exp;
        forever begin
            @(negedge clk);
            n_checks++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL sb_a_empty @%0t: got no expectation, want one per cycle", $time);
            end else begin
                exp = q_a.pop_front();
                act.sel = sel_a; act.w = w_a; act.an = an_a; act.tick = tick_a;
                check_out("dut_a", act, exp);
            end
            n_checks++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL sb_b_empty @%0t: got no expectation, want one per cycle", $time);
            end else begin
                exp = q_b.pop_front();
                act.sel = sel_b; act.w = w_b; act.an = an_b; act.tick = tick_b;
                check_out("dut_b", act, exp);
            end
        end
    end

    // Wait (bounded) until the scan sits at a given frame position.
    task automatic wait_phase(input int ph);
        bit found = 1'b0;
        for (int n = 0; n < 3 * FRAME; n++) begin
            @(negedge clk);
            if (m_act[0] && (m_t[0] % FRAME == ph)) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_phase: got no frame position %0d within %0d cycles", ph, 3 * FRAME);
        end
    endtask

    // Stimulus sequence.
    initial begin
        int ticks_a;
        int ticks_b;
        rst = 1'b1; en = 1'b0; i = 4'hA; p = 4'h5;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Five clean frames: count frame ticks on both instances.
        en = 1'b1;
        ticks_a = 0;
        ticks_b = 0;
        for (int n = 0; n < 5 * FRAME; n++) begin
            @(negedge clk);
            ticks_a += int'(tick_a);
            ticks_b += int'(tick_b);
        end
        n_checks++;
        if (ticks_a != 5) begin
            n_fail++;
            $display("FAIL tick_count_a: got %0d, want 5", ticks_a);
        end
        n_checks++;
        if (ticks_b != 5) begin
            n_fail++;
            $display("FAIL tick_count_b: got %0d, want 5", ticks_b);
        end

        // Change p in the middle of the digit-1 display.
        wait_phase(14);
        p = 4'hC;
        repeat (5) @(negedge clk);

        // Drop en on the fourth visible cycle of digit 1, then re-enable.
        wait_phase(15);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (25) @(negedge clk);

        // Apply a one-cycle reset in the middle of the digit-0 display.
        wait_phase(5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (45) @(negedge clk);

        // Random inputs with occasional en drops and resets.
        for (int n = 0; n < 800; n++) begin
            i   = 4'($urandom);
            p   = 4'($urandom);
            en  = ($urandom_range(0, 39) != 0);
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        en  = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
